// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t      : sequencer states (3-bit encoding)
//   PORT0/PORT1  : requester ids as stored in the grant/port registers
//   DEF_TIMEOUT  : default bound on cycles spent waiting for the memory
//   SM_W         : width of the access size/sign code
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_STALL_HI = 3'd2,
    S_STALL_LO = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic PORT0       = 1'b0;
  localparam logic PORT1       = 1'b1;
  localparam int   DEF_TIMEOUT = 15;
  localparam int   SM_W        = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   m0_* / m1_*   : request side (req, we, addr, wdata, sign_mask in;
//                   done, rdata out of the arbiter)
//   err           : timeout flag, pulses together with done
//   mem_*         : memory port (addr, write data, sign mask, read/write
//                   strobes out of the arbiter; read data, stall in)
// Modports: slave = the arbiter's view, master = the surrounding system.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              m0_req,       m1_req;
  logic              m0_we,        m1_we;
  logic [ADDR_W-1:0] m0_addr,      m1_addr;
  logic [DATA_W-1:0] m0_wdata,     m1_wdata;
  logic [SM_W-1:0]   m0_sign_mask, m1_sign_mask;
  logic              m0_done,      m1_done;
  logic [DATA_W-1:0] m0_rdata,     m1_rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [SM_W-1:0]   mem_sign_mask;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_clk_stall;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_sign_mask, m1_sign_mask,
           mem_read_data, mem_clk_stall,
    output m0_done, m1_done, m0_rdata, m1_rdata, err,
           mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_sign_mask, m1_sign_mask,
           mem_read_data, mem_clk_stall,
    input  m0_done, m1_done, m0_rdata, m1_rdata, err,
           mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
//   i_req[1:0]   : request per port
//   i_last_grant : port that won the previous arbitration
//   i_enable     : grants are only issued while high
//   o_grant[1:0] : one-hot grant, all zero when disabled or idle
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);
  always_comb begin
    // NOTE: default assigned first so every path drives o_grant; no latch.
    o_grant = 2'b00;
    if (i_enable) begin
      unique case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        // Tie: the port that did not win last time goes next.
        2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the load/store unit (port 0) and an
// auxiliary master (port 1). One transaction in flight; round-robin grant;
// drives a one-cycle strobe, waits for stall to rise then fall, returns
// read data with a one-cycle done pulse. A stuck memory is cut off after
// TIMEOUT stall-wait cycles with err and zeroed read data.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requesters and memory port)
// All outputs come straight from registers.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int             CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] L_TMO = TIMEOUT[CNT_W:0];

  state_t            r_state, w_state_next;
  logic              r_last_grant, r_port, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [SM_W-1:0]   r_sign_mask;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_memread, r_memwrite, r_done0, r_done1, r_err;

  logic [1:0]        w_grant;
  logic              w_sel, w_timeout;
  logic [CNT_W:0]    w_cnt_inc;

  rr_arb2 u_arb (
    .i_req        ({bus.m1_req, bus.m0_req}),
    .i_last_grant (r_last_grant),
    // Holding off while stall is high lets a pre-reset access drain.
    .i_enable     ((r_state == S_IDLE) && !bus.mem_clk_stall),
    .o_grant      (w_grant)
  );

  assign w_sel = w_grant[1];

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_cnt_inc    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    unique case (r_state)
      S_IDLE:  if (|w_grant) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_STALL_HI;
      // Timeout wins here so the counter can never run past TIMEOUT.
      S_STALL_HI: begin
        if (w_cnt_inc >= L_TMO) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end else if (bus.mem_clk_stall) begin
          w_state_next = S_STALL_LO;
        end
      end
      // A completion landing on the timeout edge is honoured as normal.
      S_STALL_LO: begin
        if (!bus.mem_clk_stall) begin
          w_state_next = S_DONE;
        end else if (w_cnt_inc >= L_TMO) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= PORT1;
      r_port       <= PORT0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sign_mask  <= '0;
      r_cnt        <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err      <= 1'b0;

      if (|w_grant) begin
        r_port       <= w_sel;
        r_last_grant <= w_sel;
        r_we         <= w_sel ? bus.m1_we        : bus.m0_we;
        r_addr       <= w_sel ? bus.m1_addr      : bus.m0_addr;
        r_wdata      <= w_sel ? bus.m1_wdata     : bus.m0_wdata;
        r_sign_mask  <= w_sel ? bus.m1_sign_mask : bus.m0_sign_mask;
        r_memread    <= w_sel ? !bus.m1_we       : !bus.m0_we;
        r_memwrite   <= w_sel ? bus.m1_we        : bus.m0_we;
      end

      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_STALL_HI || r_state == S_STALL_LO)
        r_cnt <= w_cnt_inc[CNT_W-1:0];

      // Only the stall states lead to DONE, so this fires once per access.
      if (w_state_next == S_DONE) begin
        r_done0 <= (r_port == PORT0);
        r_done1 <= (r_port == PORT1);
        r_err   <= w_timeout;
        if (w_timeout) begin
          if (r_port == PORT1) r_rdata1 <= '0;
          else                 r_rdata0 <= '0;
        end else if (!r_we) begin
          if (r_port == PORT1) r_rdata1 <= bus.mem_read_data;
          else                 r_rdata0 <= bus.mem_read_data;
        end
      end
    end
  end

  assign bus.m0_done        = r_done0;
  assign bus.m1_done        = r_done1;
  assign bus.m0_rdata       = r_rdata0;
  assign bus.m1_rdata       = r_rdata1;
  assign bus.err            = r_err;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_sign_mask  = r_sign_mask;
  assign bus.mem_memread    = r_memread;
  assign bus.mem_memwrite   = r_memwrite;
endmodule
